apb_slave_if: RTL and testbench
===============================

// Module: apb_slave_if
// PURPOSE
// - APB4 slave front end for the UART register file; converts PSEL/PENABLE/PREADY transfers into
//   single-cycle en_o/wr_rd_o/addr_o strobes for the register file.
// - Collects the register file's registered read data and addr_err, then returns PRDATA/PREADY/PSLVERR.
// - Sits between the system APB interconnect and the register file. One transfer is outstanding at a time.
// PARAMETERS
// - ADDR_W       12     APB address width; low 12 bits go to the register file.
// - WAIT_STATES  0      Extra WAIT cycles inserted before PREADY (0..15).
// - ADDR_LIMIT   12'h028  First out-of-range byte address. At or above it -> PSLVERR, no en_o.
// PORTS
// - clk            in   1       Clock; all logic is on the rising edge.
// - reset          in   1       Synchronous, active-high reset.
// - psel_i         in   1       APB select.
// - penable_i      in   1       APB enable (access phase).
// - pwrite_i       in   1       1 = write, 0 = read.
// - paddr_i        in   ADDR_W  Byte address.
// - pwdata_i       in   32      Write data.
// - pstrb_i        in   4       Write byte strobes.
// - pready_o       out  1       Transfer complete.
// - prdata_o       out  32      Read data; valid when pready_o && !pwrite_i.
// - pslverr_o      out  1       Error response; valid only while pready_o is high.
// - addr_o         out  12      Register file address.
// - wr_rd_o        out  1       Register file direction (1 = write).
// - en_o           out  1       Register file enable; a one-cycle pulse per transfer.
// - pwdata_o       out  32      Register file write data.
// - byte_strobe_o  out  4       Register file byte strobes; forced to 0 on reads.
// - rf_prdata_i    in   32      Register file read data; registered, valid 1 cycle after en_o.
// - rf_addr_err_i  in   1       Register file address error; registered, valid 1 cycle after en_o.
// BEHAVIOUR
// - Reset: all outputs 0, FSM in IDLE, wait counter 0, response registers 0.
// - FSM states: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
//   - IDLE: on an edge with psel_i && !penable_i, capture paddr/pwrite/pwdata/pstrb and go to ISSUE.
//   - ISSUE: en_o = 1 for exactly this cycle, using the captured fields. Exception: if paddr[1:0] != 0
//     or paddr >= ADDR_LIMIT, en_o stays 0 and a local error flag is set. Load the wait counter with
//     WAIT_STATES, then go to WAIT.
//   - WAIT: on its first cycle, capture rf_prdata_i (reads only; 0 for writes) and
//     rf_addr_err_i | local error. Decrement the counter; go to DONE when it reaches 0.
//   - DONE: pready_o = 1; prdata_o and pslverr_o come from the response registers. On an edge with
//     psel_i && penable_i, go to IDLE.
// - Latency (WAIT_STATES = 0): SETUP in cycle 0, pready_o high in cycle 3. This is 2 APB wait states
//   plus WAIT_STATES.
// - prdata_o is 0 whenever pready_o = 0, and 0 for write responses.
// - A write with pstrb = 4'h0 still pulses en_o; no byte changes and PSLVERR = 0.
// - Errored writes update no register.
// - psel_i falls before DONE: abort to IDLE with no pready_o. If en_o was already issued, the register
//   file side effect stands.
// - A back-to-back SETUP while in DONE is not captured. The master must return to IDLE/SETUP first,
//   so there is one idle cycle between transfers.
// - Reset asserted mid-transfer: immediate return to IDLE, all outputs 0 next cycle, transfer dropped.
// - addr_o/wr_rd_o/pwdata_o/byte_strobe_o hold their captured values until the next capture.
// CONFIGURATION
// - APB_PROT_CHECK_EN defined:
//   - Adds output prot_err_o (1 bit, sticky, reset 0).
//   - Sets it on: psel && penable while in IDLE; paddr/pwrite/pwdata/pstrb differing from the captured
//     values during ISSUE/WAIT/DONE while psel is high; psel falling before DONE.
//   - A violation during ISSUE/WAIT also forces pslverr_o = 1 on that transfer's response.
// - APB_PROT_CHECK_EN undefined: no prot_err_o port, no checks. Violations behave as described above.
// TESTING
// - Write 32'hA5A5_0055 to 12'h008, pstrb=4'hF: en_o=1, wr_rd_o=1 in cycle 1; pready_o in cycle 3;
//   pslverr=0; LCR=32'hA5A5_0055.
// - Read 12'h008 after the write: pready_o in cycle 3, prdata_o=32'hA5A5_0055, pslverr=0;
//   byte_strobe_o=0.
// - Write 12'h002 (misaligned) and read 12'h030 (>= ADDR_LIMIT): en_o never asserts; pslverr=1;
//   prdata=0.
// - Read 12'h024 with WAIT_STATES=3: pready_o first asserts in cycle 6; prdata holds until the
//   handshake.
// - Write 12'h01C, psel dropped in WAIT: no pready_o, FSM back in IDLE. With APB_PROT_CHECK_EN,
//   prot_err_o=1 until reset.
// - Reset asserted in WAIT: next cycle pready_o=0, en_o=0, prdata_o=0; a following read of 12'h000
//   completes normally.

Source files
------------

// File: rtl/apb_slave_if_if.sv
// APB4 bus bundle between the system interconnect and the UART register-file front end.
interface apb_slave_if_if #(
  parameter int unsigned ADDR_W = 12
);
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [31:0]       pwdata;
  logic [3:0]        pstrb;
  logic              pready;
  logic [31:0]       prdata;
  logic              pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb,
    output pready, prdata, pslverr
  );
endinterface

// File: rtl/apb_slave_if.sv
// APB4 slave front end for the UART register file: one outstanding transfer, single-cycle en_o strobe.
// Optional protocol checker and prot_err_o port enabled by defining APB_PROT_CHECK_EN.
module apb_slave_if #(
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [11:0] ADDR_LIMIT  = 12'h028
) (
  input  logic          clk,
  input  logic          reset,
  apb_slave_if_if.slave apb,
  output logic [11:0]   addr_o,
  output logic          wr_rd_o,
  output logic          en_o,
  output logic [31:0]   pwdata_o,
  output logic [3:0]    byte_strobe_o,
  input  logic [31:0]   rf_prdata_i,
  input  logic          rf_addr_err_i
`ifdef APB_PROT_CHECK_EN
  ,
  output logic          prot_err_o
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        first_q;
  logic        lerr_q;
  logic        en_q;
  logic        wr_q;
  logic        pready_q;
  logic        err_q;
  logic [11:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic [3:0]  strb_q;
  logic        lerr_d;
  logic        force_err;

  always_comb begin
    lerr_d = (apb.paddr[1:0] != 2'b00) || (apb.paddr >= ADDR_W'(ADDR_LIMIT));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      first_q  <= 1'b0;
      lerr_q   <= 1'b0;
      en_q     <= 1'b0;
      wr_q     <= 1'b0;
      pready_q <= 1'b0;
      err_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      strb_q   <= '0;
    end else begin
      en_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (apb.psel && !apb.penable) begin
            addr_q  <= apb.paddr[11:0];
            wr_q    <= apb.pwrite;
            wdata_q <= apb.pwdata;
            strb_q  <= apb.pwrite ? apb.pstrb : '0;
            lerr_q  <= lerr_d;
            en_q    <= !lerr_d;
            state_q <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (!apb.psel) begin
            state_q <= ST_IDLE;
          end else begin
            cnt_q   <= 4'(WAIT_STATES);
            first_q <= 1'b1;
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          first_q <= 1'b0;
          if (!apb.psel) begin
            state_q <= ST_IDLE;
          end else begin
            // Register-file response is only valid on the first WAIT cycle.
            if (first_q) begin
              rdata_q <= (wr_q || lerr_q) ? '0 : rf_prdata_i;
              err_q   <= rf_addr_err_i || lerr_q;
            end
            if (cnt_q == '0) begin
              state_q  <= ST_DONE;
              pready_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q - 4'd1;
            end
          end
        end
        ST_DONE: begin
          if (apb.psel && apb.penable) begin
            state_q  <= ST_IDLE;
            pready_q <= 1'b0;
          end
        end
      endcase
    end
  end

`ifdef APB_PROT_CHECK_EN
  logic [ADDR_W-1:0] paddr_cap_q;
  logic [3:0]        pstrb_cap_q;
  logic              prot_q;
  logic              viol_q;
  logic              mismatch;
  logic              pre_done;
  logic              viol_d;

  always_comb begin
    pre_done = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
    mismatch = (apb.paddr != paddr_cap_q) || (apb.pwrite != wr_q) ||
               (apb.pwdata != wdata_q) || (apb.pstrb != pstrb_cap_q);
    viol_d   = ((state_q == ST_IDLE) && apb.psel && apb.penable) ||
               ((state_q != ST_IDLE) && apb.psel && mismatch) ||
               (pre_done && !apb.psel);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      paddr_cap_q <= '0;
      pstrb_cap_q <= '0;
      prot_q      <= 1'b0;
      viol_q      <= 1'b0;
    end else begin
      if ((state_q == ST_IDLE) && apb.psel && !apb.penable) begin
        paddr_cap_q <= apb.paddr;
        pstrb_cap_q <= apb.pstrb;
        viol_q      <= 1'b0;
      end else if (pre_done && apb.psel && mismatch) begin
        viol_q <= 1'b1;
      end
      if (viol_d) begin
        prot_q <= 1'b1;
      end
    end
  end

  assign prot_err_o = prot_q;
  assign force_err  = viol_q;
`else
  assign force_err  = 1'b0;
`endif

  assign apb.pready    = pready_q;
  assign apb.prdata    = pready_q ? rdata_q : '0;
  assign apb.pslverr   = pready_q & (err_q | force_err);
  assign addr_o        = addr_q;
  assign wr_rd_o       = wr_q;
  assign en_o          = en_q;
  assign pwdata_o      = wdata_q;
  assign byte_strobe_o = strb_q;

endmodule

// File: tb/tb_apb_slave_if.sv
// Bench for apb_slave_if: a 0-wait-state and a 3-wait-state instance, each with a register-file
// stand-in whose response is valid only the cycle after en_o; responses checked via a scoreboard queue.
module tb_apb_slave_if;
  localparam int unsigned NI = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst     [NI];
  logic        psel    [NI];
  logic        pen     [NI];
  logic        pwr     [NI];
  logic [11:0] paddr   [NI];
  logic [31:0] pwdata  [NI];
  logic [3:0]  pstrb   [NI];
  logic        pready  [NI];
  logic [31:0] prdata  [NI];
  logic        pslverr [NI];
  logic [11:0] addr_o  [NI];
  logic        wr_o    [NI];
  logic        en_o    [NI];
  logic [31:0] wd_o    [NI];
  logic [3:0]  bs_o    [NI];
`ifdef APB_PROT_CHECK_EN
  logic        prot    [NI];
`endif

  for (genvar g = 0; g < NI; g++) begin : gi
    apb_slave_if_if #(.ADDR_W(12)) bus ();
    logic [11:0] a_o;
    logic        w_o;
    logic        e_o;
    logic [31:0] d_o;
    logic [3:0]  s_o;
    logic [31:0] rd_q;
    logic        err_q;
    logic [31:0] mem [16];

    assign bus.psel    = psel[g];
    assign bus.penable = pen[g];
    assign bus.pwrite  = pwr[g];
    assign bus.paddr   = paddr[g];
    assign bus.pwdata  = pwdata[g];
    assign bus.pstrb   = pstrb[g];
    assign pready[g]   = bus.pready;
    assign prdata[g]   = bus.prdata;
    assign pslverr[g]  = bus.pslverr;
    assign addr_o[g]   = a_o;
    assign wr_o[g]     = w_o;
    assign en_o[g]     = e_o;
    assign wd_o[g]     = d_o;
    assign bs_o[g]     = s_o;

    apb_slave_if #(
      .ADDR_W      (12),
      .WAIT_STATES (g * 3),
      .ADDR_LIMIT  (12'h028)
    ) dut (
      .clk           (clk),
      .reset         (rst[g]),
      .apb           (bus.slave),
      .addr_o        (a_o),
      .wr_rd_o       (w_o),
      .en_o          (e_o),
      .pwdata_o      (d_o),
      .byte_strobe_o (s_o),
      .rf_prdata_i   (rd_q),
      .rf_addr_err_i (err_q)
`ifdef APB_PROT_CHECK_EN
      ,
      .prot_err_o    (prot[g])
`endif
    );

    initial for (int i = 0; i < 16; i++) mem[i] = '0;

    // Register-file stand-in: 0x020 is a reserved (erroring) register; garbage when not accessed.
    always @(posedge clk) begin
      if (e_o) begin
        err_q <= (a_o == 12'h020);
        rd_q  <= (!w_o && a_o != 12'h020) ? mem[a_o[5:2]] : 32'h0;
        if (w_o && a_o != 12'h020)
          for (int b = 0; b < 4; b++)
            if (s_o[b]) mem[a_o[5:2]][8*b +: 8] <= d_o[8*b +: 8];
      end else begin
        err_q <= 1'b1;
        rd_q  <= 32'hBAD0_BAD0;
      end
    end
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int unsigned lat;
  } exp_t;

  typedef struct {
    logic        wr;
    logic [11:0] a;
    logic [31:0] wd;
    logic [3:0]  st;
    logic [31:0] rd;
    logic        err;
    logic        en;
  } vec_t;

  exp_t        sb[$];
  vec_t        tbl[14];
  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic xfer(input int k, input logic wr, input logic [11:0] a, input logic [31:0] wd,
                      input logic [3:0] st, input logic [31:0] exp_rd, input logic exp_err,
                      input logic exp_en, input int unsigned hold);
    exp_t        e;
    int unsigned cyc;
    int unsigned ens;
    @(posedge clk); #1;
    psel[k] = 1'b1; pen[k] = 1'b0; pwr[k] = wr;
    paddr[k] = a; pwdata[k] = wd; pstrb[k] = st;
    e.rdata = exp_rd; e.err = exp_err; e.lat = (k == 0) ? 3 : 6;
    sb.push_back(e);
    @(posedge clk); #1;
    pen[k] = 1'b1;
    cyc = 1;
    chk($sformatf("en_o cycle1 @%h", a), en_o[k], exp_en);
    if (exp_en) begin
      chk($sformatf("addr_o @%h", a), addr_o[k], a);
      chk($sformatf("wr_rd_o @%h", a), wr_o[k], wr);
      chk($sformatf("byte_strobe_o @%h", a), bs_o[k], wr ? st : 4'h0);
      if (wr) chk($sformatf("pwdata_o @%h", a), wd_o[k], wd);
    end
    ens = 0;
    while (!pready[k] && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (en_o[k]) ens++;
    end
    e = sb.pop_front();
    chk($sformatf("extra en_o @%h", a), ens, 0);
    chk($sformatf("latency @%h", a), cyc, e.lat);
    chk($sformatf("prdata @%h", a), prdata[k], e.rdata);
    chk($sformatf("pslverr @%h", a), pslverr[k], e.err);
    if (hold != 0) begin
      pen[k] = 1'b0;
      repeat (hold) begin
        @(posedge clk); #1;
        chk("pready held", pready[k], 1);
        chk("prdata held", prdata[k], e.rdata);
      end
      pen[k] = 1'b1;
    end
    @(posedge clk); #1;
    psel[k] = 1'b0; pen[k] = 1'b0;
    chk($sformatf("pready after handshake @%h", a), pready[k], 0);
    chk($sformatf("prdata after handshake @%h", a), prdata[k], 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned seen;
    for (int k = 0; k < NI; k++) begin
      rst[k] = 1'b1; psel[k] = 1'b0; pen[k] = 1'b0; pwr[k] = 1'b0;
      paddr[k] = '0; pwdata[k] = '0; pstrb[k] = '0;
    end

    tbl[0]  = '{1'b1, 12'h008, 32'hA5A5_0055, 4'hF, 32'h0,         1'b0, 1'b1};
    tbl[1]  = '{1'b0, 12'h008, 32'h0,         4'hF, 32'hA5A5_0055, 1'b0, 1'b1};
    tbl[2]  = '{1'b1, 12'h002, 32'h1234_5678, 4'hF, 32'h0,         1'b1, 1'b0};
    tbl[3]  = '{1'b0, 12'h030, 32'h0,         4'h0, 32'h0,         1'b1, 1'b0};
    tbl[4]  = '{1'b1, 12'h00C, 32'h1122_3344, 4'h5, 32'h0,         1'b0, 1'b1};
    tbl[5]  = '{1'b0, 12'h00C, 32'h0,         4'h0, 32'h0022_0044, 1'b0, 1'b1};
    tbl[6]  = '{1'b1, 12'h010, 32'hFFFF_FFFF, 4'h0, 32'h0,         1'b0, 1'b1};
    tbl[7]  = '{1'b0, 12'h010, 32'h0,         4'h0, 32'h0,         1'b0, 1'b1};
    tbl[8]  = '{1'b0, 12'h020, 32'h0,         4'h0, 32'h0,         1'b1, 1'b1};
    tbl[9]  = '{1'b0, 12'h028, 32'h0,         4'h0, 32'h0,         1'b1, 1'b0};
    tbl[10] = '{1'b1, 12'h024, 32'hDEAD_BEEF, 4'hF, 32'h0,         1'b0, 1'b1};
    tbl[11] = '{1'b0, 12'h024, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0, 1'b1};
    tbl[12] = '{1'b1, 12'h00A, 32'h0,         4'hF, 32'h0,         1'b1, 1'b0};
    tbl[13] = '{1'b0, 12'h008, 32'h0,         4'h0, 32'hA5A5_0055, 1'b0, 1'b1};

    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) begin
      chk("reset pready", pready[k], 0);
      chk("reset prdata", prdata[k], 0);
      chk("reset pslverr", pslverr[k], 0);
      chk("reset en_o", en_o[k], 0);
      chk("reset wr_rd_o", wr_o[k], 0);
      chk("reset addr_o", addr_o[k], 0);
      chk("reset pwdata_o", wd_o[k], 0);
      chk("reset byte_strobe_o", bs_o[k], 0);
`ifdef APB_PROT_CHECK_EN
      chk("reset prot_err_o", prot[k], 0);
`endif
      rst[k] = 1'b0;
    end

    for (int i = 0; i < 14; i++)
      xfer(0, tbl[i].wr, tbl[i].a, tbl[i].wd, tbl[i].st, tbl[i].rd, tbl[i].err, tbl[i].en, 0);
`ifdef APB_PROT_CHECK_EN
    chk("prot_err_o clean traffic", prot[0], 0);
`endif

    // Three wait states: response holds while the master delays the handshake.
    xfer(1, 1'b1, 12'h024, 32'h5A5A_A5A5, 4'hF, 32'h0, 1'b0, 1'b1, 0);
    xfer(1, 1'b0, 12'h024, 32'h0, 4'h0, 32'h5A5A_A5A5, 1'b0, 1'b1, 2);
    xfer(1, 1'b0, 12'h030, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0, 0);

    // Abort in WAIT after en_o: no response, register write still lands.
    @(posedge clk); #1;
    psel[0] = 1'b1; pen[0] = 1'b0; pwr[0] = 1'b1;
    paddr[0] = 12'h01C; pwdata[0] = 32'h0BAD_F00D; pstrb[0] = 4'hF;
    @(posedge clk); #1;
    pen[0] = 1'b1;
    chk("abort en_o cycle1", en_o[0], 1);
    @(posedge clk); #1;
    psel[0] = 1'b0; pen[0] = 1'b0;
    seen = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (pready[0]) seen++;
    end
    chk("abort pready cycles", seen, 0);
`ifdef APB_PROT_CHECK_EN
    chk("abort prot_err_o", prot[0], 1);
`endif
    xfer(0, 1'b0, 12'h01C, 32'h0, 4'h0, 32'h0BAD_F00D, 1'b0, 1'b1, 0);

    // Reset asserted in WAIT drops the transfer.
    @(posedge clk); #1;
    psel[0] = 1'b1; pen[0] = 1'b0; pwr[0] = 1'b0; paddr[0] = 12'h008; pstrb[0] = 4'h0;
    @(posedge clk); #1;
    pen[0] = 1'b1;
    @(posedge clk); #1;
    rst[0] = 1'b1;
    @(posedge clk); #1;
    rst[0] = 1'b0; psel[0] = 1'b0; pen[0] = 1'b0;
    chk("reset-in-wait pready", pready[0], 0);
    chk("reset-in-wait en_o", en_o[0], 0);
    chk("reset-in-wait prdata", prdata[0], 0);
`ifdef APB_PROT_CHECK_EN
    chk("reset-in-wait prot_err_o", prot[0], 0);
`endif
    xfer(0, 1'b0, 12'h000, 32'h0, 4'h0, 32'h0, 1'b0, 1'b1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
